// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: read-side controller for the two-master / three-slave AXI
// interconnect. It picks M0 or M1 round-robin, decodes the winning address to S0,
// S1 or the default slave S2, and gates the AR and R handshakes. It holds the path
// until the RLAST handshake. Payload muxing stays in the datapath, which is
// steered by master_sel / slave_sel.
// Optional feature macro: AXI_RD_TIMEOUT_EN. When defined, a watchdog releases a
// grant that sees no AR or R handshake for TIMEOUT cycles.
module axi_read_arbiter #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_LAST = 32'h0000_FFFF,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_LAST = 32'h0001_FFFF,
  parameter int          TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  input  logic [31:0] ARADDR_M0,
  input  logic [31:0] ARADDR_M1,
  output logic        ARREADY_M0,
  output logic        ARREADY_M1,
  output logic        ARVALID_S0,
  output logic        ARVALID_S1,
  output logic        ARVALID_S2,
  input  logic        ARREADY_S0,
  input  logic        ARREADY_S1,
  input  logic        ARREADY_S2,
  input  logic        RVALID_S0,
  input  logic        RVALID_S1,
  input  logic        RVALID_S2,
  input  logic        RLAST_S0,
  input  logic        RLAST_S1,
  input  logic        RLAST_S2,
  output logic        RREADY_S0,
  output logic        RREADY_S1,
  output logic        RREADY_S2,
  output logic        RVALID_M0,
  output logic        RVALID_M1,
  input  logic        RREADY_M0,
  input  logic        RREADY_M1,
  output logic [1:0]  master_sel,
  output logic [2:0]  slave_sel,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t      r_state, w_next;
  logic        r_ptr;     // 1: M1 is favoured on a tie
  logic [1:0]  r_msel;
  logic [2:0]  r_ssel;

  logic [1:0]  w_arvalid_m, w_rready_m, w_arready_m, w_rvalid_m;
  logic [2:0]  w_arready_s, w_rvalid_s, w_rlast_s, w_arvalid_s, w_rready_s;
  logic        w_req, w_gnt_m1;
  logic [31:0] w_win_addr;
  logic [2:0]  w_dec;
  logic        w_own_arvalid, w_own_rready, w_tgt_arready, w_tgt_rvalid, w_tgt_rlast;
  logic        w_ar_hs, w_r_hs, w_r_done, w_wd_hit;

  assign w_arvalid_m = {ARVALID_M1, ARVALID_M0};
  assign w_rready_m  = {RREADY_M1, RREADY_M0};
  assign w_arready_s = {ARREADY_S2, ARREADY_S1, ARREADY_S0};
  assign w_rvalid_s  = {RVALID_S2, RVALID_S1, RVALID_S0};
  assign w_rlast_s   = {RLAST_S2, RLAST_S1, RLAST_S0};

  // The pointer breaks ties only. A lone requester always wins.
  assign w_req      = |w_arvalid_m;
  assign w_gnt_m1   = w_arvalid_m[1] & (~w_arvalid_m[0] | r_ptr);
  assign w_win_addr = w_gnt_m1 ? ARADDR_M1 : ARADDR_M0;

  // The offset-from-base form is an unsigned inclusive range check. Unlike
  // addr >= base, it does not collapse to a constant when base is 0.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] last);
    return (addr - base) <= (last - base);
  endfunction

  assign w_dec = in_range(w_win_addr, S0_BASE, S0_LAST) ? 3'b001 :
                 in_range(w_win_addr, S1_BASE, S1_LAST) ? 3'b010 : 3'b100;

  // Handshake terms seen through the registered owner / target selects
  assign w_own_arvalid = |(w_arvalid_m & r_msel);
  assign w_own_rready  = |(w_rready_m  & r_msel);
  assign w_tgt_arready = |(w_arready_s & r_ssel);
  assign w_tgt_rvalid  = |(w_rvalid_s  & r_ssel);
  assign w_tgt_rlast   = |(w_rlast_s   & r_ssel);

  assign w_ar_hs  = (r_state == ST_ADDR) & w_own_arvalid & w_tgt_arready;
  assign w_r_hs   = (r_state == ST_DATA) & w_tgt_rvalid & w_own_rready;
  assign w_r_done = w_r_hs & w_tgt_rlast;

`ifdef AXI_RD_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT) < 8) ? 8 : $clog2(TIMEOUT);
  logic [WDW-1:0] r_wdog;

  // The watchdog counts cycles without a handshake while the path is held.
  // It restarts on every AR/R handshake and on every state entry.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE || w_ar_hs || w_r_hs) r_wdog <= '0;
    else                                                r_wdog <= r_wdog + WDW'(1);
  end

  assign w_wd_hit = (r_state != ST_IDLE) & ~(w_ar_hs | w_r_hs) &
                    (r_wdog == WDW'(TIMEOUT - 1));
  assign timeout  = w_wd_hit;
`else
  // Without the watchdog, a hung slave keeps the grant until reset.
  assign w_wd_hit = 1'b0;
  assign timeout  = 1'b0;
  // TIMEOUT only sizes the watchdog. It is referenced here so that the default
  // build still consumes it.
  generate
    if (TIMEOUT > 0) begin : g_wd_absent
    end
  endgenerate
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. A watchdog hit overrides everything else.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req)    w_next = ST_ADDR;
      ST_ADDR: if (w_ar_hs)  w_next = ST_DATA;
      ST_DATA: if (w_r_done) w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
    if (w_wd_hit) w_next = ST_IDLE;
  end

  // Grant capture: the selects are loaded on a grant and cleared on release.
  // The pointer moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= 1'b0;
      r_msel <= '0;
      r_ssel <= '0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_msel <= {w_gnt_m1, ~w_gnt_m1};
      r_ssel <= w_dec;
      r_ptr  <= ~w_gnt_m1;
    end else if (r_state != ST_IDLE && w_next == ST_IDLE) begin
      r_msel <= '0;
      r_ssel <= '0;
    end
  end

  // Handshake gating: only the owning master and the selected slave see a
  // channel, and only in the phase that uses it.
  always_comb begin
    w_arvalid_s = '0;
    w_arready_m = '0;
    w_rready_s  = '0;
    w_rvalid_m  = '0;
    case (r_state)
      ST_ADDR: begin
        w_arvalid_s = r_ssel & {3{w_own_arvalid}};
        w_arready_m = r_msel & {2{w_tgt_arready}};
      end
      ST_DATA: begin
        w_rvalid_m = r_msel & {2{w_tgt_rvalid}};
        w_rready_s = r_ssel & {3{w_own_rready}};
      end
      default: ;
    endcase
  end

  assign {ARVALID_S2, ARVALID_S1, ARVALID_S0} = w_arvalid_s;
  assign {ARREADY_M1, ARREADY_M0}             = w_arready_m;
  assign {RREADY_S2, RREADY_S1, RREADY_S0}    = w_rready_s;
  assign {RVALID_M1, RVALID_M0}               = w_rvalid_m;
  assign master_sel = r_msel;
  assign slave_sel  = r_ssel;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter. The model tracks the arbitration
// pointer and each transaction's phase from the handshakes the bench drives. Every
// cycle, it compares the full output bundle against the gating rules.
module tb_axi_read_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  arv_m, rr_m;
  logic [31:0] addr_m [2];
  logic [2:0]  ars, rvs, rls;
  logic [1:0]  arr_m, rv_m, msel;
  logic [2:0]  arv_s, rr_s, ssel;
  logic        busy, tmo;
  logic [16:0] act;
  logic [31:0] rnd;

  int checks   = 0;
  int failures = 0;
  int prio     = 0;   // model: master favoured on a tie

  always #5 clk = ~clk;

  axi_read_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ARVALID_M0(arv_m[0]), .ARVALID_M1(arv_m[1]),
    .ARADDR_M0(addr_m[0]), .ARADDR_M1(addr_m[1]),
    .ARREADY_M0(arr_m[0]), .ARREADY_M1(arr_m[1]),
    .ARVALID_S0(arv_s[0]), .ARVALID_S1(arv_s[1]), .ARVALID_S2(arv_s[2]),
    .ARREADY_S0(ars[0]), .ARREADY_S1(ars[1]), .ARREADY_S2(ars[2]),
    .RVALID_S0(rvs[0]), .RVALID_S1(rvs[1]), .RVALID_S2(rvs[2]),
    .RLAST_S0(rls[0]), .RLAST_S1(rls[1]), .RLAST_S2(rls[2]),
    .RREADY_S0(rr_s[0]), .RREADY_S1(rr_s[1]), .RREADY_S2(rr_s[2]),
    .RVALID_M0(rv_m[0]), .RVALID_M1(rv_m[1]),
    .RREADY_M0(rr_m[0]), .RREADY_M1(rr_m[1]),
    .master_sel(msel), .slave_sel(ssel), .busy(busy), .timeout(tmo)
  );

  assign act = {busy, msel, ssel, arv_s, arr_m, rr_s, rv_m, tmo};

  // Address map: S0 covers 0..0xFFFF (it starts at address 0), and S1 covers
  // 0x1_0000..0x1_FFFF. Anything else goes to S2.
  function automatic int dec(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    return 2;
  endfunction

  // Expected outputs for a phase (0 idle, 1 address, 2 data), owner w, target k,
  // given the inputs currently driven.
  function automatic logic [16:0] exp_out(input int ph, input int w, input int k);
    logic [1:0] mo, arm, rvm;
    logic [2:0] so, avs, rrs;
    mo = '0; so = '0; arm = '0; rvm = '0; avs = '0; rrs = '0;
    mo[w] = 1'b1;
    so[k] = 1'b1;
    if (ph == 0) return '0;
    if (ph == 1) begin
      if (arv_m[w]) avs = so;
      if (ars[k])   arm = mo;
    end else begin
      if (rvs[k])   rvm = mo;
      if (rr_m[w])  rrs = so;
    end
    return {1'b1, mo, so, avs, arm, rrs, rvm, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_inputs();
    arv_m = '0; rr_m = '0; ars = '0; rvs = '0; rls = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    step();
    step();
    rst = 1'b0;
    prio = 0;
  endtask

  // One full read: arbitration, optional AR wait states (with ARVALID dropped at
  // random), and an R burst of nbeats. Backpressure is random, or toggles
  // 1,0,1,... when tog is set. With keep_loser, the losing requester keeps
  // ARVALID high throughout.
  task automatic do_txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input int nbeats, input int ar_wait, input bit keep_loser,
                        input bit tog, input string tag);
    int w, k, hs, cyc, dry;
    logic [16:0] e;
    addr_m[0] = a0; addr_m[1] = a1;
    arv_m = req; ars = '0; rvs = '0; rls = '0; rr_m = '0;
    #1;
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s idle: got %05h want %05h", tag, act, 17'h0);
    end
    w = (req == 2'b11) ? prio : (req[1] ? 1 : 0);
    k = dec(w == 1 ? a1 : a0);
    prio = 1 - w;
    step();
    e = exp_out(1, w, k);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s grant: got %05h want %05h", tag, act, e);
    end
    for (int i = 0; i < ar_wait; i++) begin
      rnd = $urandom;
      arv_m[w] = rnd[0];
      ars = rnd[3:1];
      ars[k] = 1'b0;
      #1;
      e = exp_out(1, w, k);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s ar_wait: got %05h want %05h", tag, act, e);
      end
      step();
    end
    arv_m[w] = 1'b1;
    ars[k] = 1'b1;
    #1;
    e = exp_out(1, w, k);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s ar_hs: got %05h want %05h", tag, act, e);
    end
    step();
    arv_m = '0;
    if (keep_loser) arv_m[1 - w] = req[1 - w];
    ars = '0;
    hs = 0; cyc = 0; dry = 0;
    while (hs < nbeats && cyc < 400) begin
      rnd = $urandom;
      rvs = rnd[2:0]; rr_m = rnd[4:3]; rls = rnd[7:5];
      if (tog) begin rvs[k] = 1'b1; rr_m[w] = ~cyc[0]; end
      if (dry >= 8) begin rvs[k] = 1'b1; rr_m[w] = 1'b1; end
      rls[k] = (hs == nbeats - 1);
      #1;
      e = exp_out(2, w, k);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s data: got %05h want %05h", tag, act, e);
      end
      if (rvs[k] && rr_m[w]) begin hs++; dry = 0; end else dry++;
      step();
      cyc++;
    end
    checks++;
    if (hs != nbeats) begin
      failures++;
      $display("FAIL %s beats: got %0d want %0d", tag, hs, nbeats);
    end
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s release: got %05h want %05h", tag, act, 17'h0);
    end
    rvs = '0; rr_m = '0; rls = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arv_m = 2'b11; ars = 3'b111; rvs = 3'b111; rls = 3'b111; rr_m = 2'b11;
    addr_m[0] = 32'h40; addr_m[1] = 32'h1_0000;
    step();
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL reset: got %05h want %05h", act, 17'h0);
    end
    clr_inputs();
    rst = 1'b0;
    prio = 0;
    step();
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL reset_idle: got %05h want %05h", act, 17'h0);
    end
  endtask

  task automatic test_single_s0();
    do_txn(2'b01, 32'h0000_0040, 32'h0, 1, 0, 1'b0, 1'b0, "single_s0");
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, $urandom, $urandom_range(32'h1_FFFF, 0), 1 + i, i, 1'b0, 1'b0, "simul");
  endtask

  task automatic test_decode();
    logic [31:0] av [8];
    av = '{32'h0001_0004, 32'h1000_0000, 32'h0000_FFFF, 32'h0001_0000,
           32'h0001_FFFF, 32'h0002_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    for (int i = 0; i < 8; i++)
      do_txn((i % 2 == 0) ? 2'b01 : 2'b10, av[i], av[i], 1, 0, 1'b0, 1'b0, "decode");
  endtask

  task automatic test_burst_backpressure();
    do_txn(2'b10, 32'h0, 32'h0001_0100, 4, 1, 1'b0, 1'b1, "burst_bp");
  endtask

  task automatic test_wait_during_busy();
    do_txn(2'b11, 32'h0000_1000, 32'h0001_2000, 3, 2, 1'b1, 1'b0, "wait_busy");
    do_txn(arv_m, 32'h0000_1000, 32'h0001_2000, 2, 0, 1'b0, 1'b0, "wait_next");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    addr_m[0] = 32'h0000_0200; addr_m[1] = 32'h0;
    arv_m = 2'b01;
    step();                      // M0 granted, pointer now favours M1
    ars = 3'b001;
    step();                      // AR handshake, now in DATA
    arv_m = '0; ars = '0;
    rvs = 3'b001; rr_m = 2'b01; rls = 3'b000;
    step();                      // beat 1
    rst = 1'b1;                  // reset during beat 2
    step();
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL rst_mid: got %05h want %05h", act, 17'h0);
    end
    rst = 1'b0;
    clr_inputs();
    prio = 0;
    do_txn(2'b11, 32'h0001_0040, 32'h2000_0000, 2, 1, 1'b0, 1'b0, "post_rst");
  endtask

`ifdef AXI_RD_TIMEOUT_EN
  task automatic test_timeout();
    logic [16:0] e;
    do_reset();
    addr_m[0] = 32'h0000_0010; addr_m[1] = 32'h0001_0010;
    arv_m = 2'b11;
    step();                      // M0 wins, M1 keeps waiting
    ars = 3'b001;
    step();
    arv_m = 2'b10; ars = '0;
    prio = 1;
    for (int c = 1; c <= TO; c++) begin
      #1;
      e = exp_out(2, 0, 0);
      e[0] = (c == TO);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL timeout_cyc%0d: got %05h want %05h", c, act, e);
      end
      step();
    end
    do_txn(2'b10, 32'h0, 32'h0001_0010, 1, 0, 1'b0, 1'b0, "after_timeout");
  endtask
`else
  task automatic test_hung_slave();
    logic [16:0] e;
    addr_m[0] = 32'h3000_0000;
    arv_m = 2'b01;
    step();
    ars = 3'b100;
    step();
    arv_m = '0; ars = '0; rr_m = 2'b01;
    for (int c = 0; c < 300; c++) begin
      rnd = $urandom;
      rvs = {1'b0, rnd[1:0]};
      #1;
      e = exp_out(2, 0, 2);
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL hung_cyc%0d: got %05h want %05h", c, act, e);
      end
      step();
    end
    rvs = 3'b100; rls = 3'b100;
    step();
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL hung_release: got %05h want %05h", act, 17'h0);
    end
    clr_inputs();
    prio = 1;                    // M0 won the hung transaction
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] pick [6];
    logic [1:0]  rq;
    pick = '{32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF,
             32'h0002_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 30; i++) begin
      rnd = $urandom;
      rq = rnd[1:0];
      if (rq == 2'b00) rq = 2'b11;
      do_txn(rq, rnd[2] ? pick[rnd[5:3] % 6] : $urandom,
             rnd[6] ? pick[rnd[9:7] % 6] : $urandom,
             1 + int'(rnd[12:10] % 6), int'(rnd[14:13]), 1'b0, 1'b0, "b2b");
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    addr_m[0] = '0; addr_m[1] = '0;
    test_reset();
    test_single_s0();
    test_simultaneous();
    test_decode();
    test_burst_backpressure();
    test_wait_during_busy();
    test_reset_mid_burst();
`ifdef AXI_RD_TIMEOUT_EN
    test_timeout();
`else
    test_hung_slave();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
